// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, pixel-grid type and score column for the
// 8x8 LED-matrix Flappy Bird controller.
package game_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2, CLEAR = 2'd3} game_state_t;
   typedef logic [7:0][7:0] grid_t;
   localparam int SCORE_COL = 6;
endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: game controller bus between the sequencer (master) and
// the board logic (slave).
interface game_sequencer_if;
   import game_pkg::*;
   logic       flap;
   grid_t      green_array;
   grid_t      red_array;
   logic       score_carry;
   logic       scroll_en;
   logic       score_en;
   logic       bird_up;
   logic       bird_down;
   logic       score_clr;
   logic       game_over;
   logic [1:0] state_o;
   modport master (
      input  flap, green_array, red_array, score_carry,
      output scroll_en, score_en, bird_up, bird_down, score_clr, game_over, state_o
   );
   modport slave (
      output flap, green_array, red_array, score_carry,
      input  scroll_en, score_en, bird_up, bird_down, score_clr, game_over, state_o
   );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: programmable divider; tick is combinational and fires when the
// count reaches div-1 (or already exceeds it after div shrinks).
module tick_gen #(
   parameter int CW = 26
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          clr,
   input  logic [CW-1:0] div,
   output logic          tick
);
   logic [CW-1:0] cnt;
   assign tick = run && cnt >= div - CW'(1);
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (clr || tick) ? '0 : run ? cnt + CW'(1) : cnt;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: Flappy Bird phase FSM, tick pulses, collision and score clear.
// Define GAME_SEQUENCER_SPEEDUP_EN to shorten the tick period on each score carry.
module game_sequencer
   import game_pkg::*;
#(
   parameter int TICK_DIV = 25_000_000,
   parameter int MIN_DIV  = 5_000_000,
   parameter int DIV_STEP = 2_500_000,
   parameter int CW       = 26
) (
   input logic               clk,
   input logic               reset,
   game_sequencer_if.master  bus
);
   game_state_t   state, state_n;
   logic [CW-1:0] cur_div;
   logic          flap_seen, flap_seen_n, tick, play, collide, fly;
   assign play    = state == PLAY;
   assign collide = play && |(bus.red_array & bus.green_array);
   assign fly     = play && !collide && bus.flap;
   tick_gen #(.CW(CW)) u_tick (
      .clk   (clk),
      .reset (reset),
      .run   (play && !collide),
      .clr   (state == IDLE || state == CLEAR),
      .div   (cur_div),
      .tick  (tick)
   );
   always_comb begin
      state_n     = state;
      flap_seen_n = flap_seen;
      state_n     = (state == IDLE && bus.flap) ? PLAY  :
                    collide                     ? DEAD  :
                    (state == DEAD && bus.flap) ? CLEAR :
                    (state == CLEAR)            ? IDLE  : state;
      flap_seen_n = (state == CLEAR || tick) ? 1'b0 : fly ? 1'b1 : flap_seen;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state         <= IDLE;
         flap_seen     <= 1'b0;
         bus.scroll_en <= 1'b0;
         bus.score_en  <= 1'b0;
         bus.bird_up   <= 1'b0;
         bus.bird_down <= 1'b0;
         bus.score_clr <= 1'b0;
         bus.game_over <= 1'b0;
         bus.state_o   <= IDLE;
      end else begin
         state         <= state_n;
         flap_seen     <= flap_seen_n;
         bus.scroll_en <= tick;
         bus.score_en  <= tick;
         bus.bird_up   <= fly;
         // a flap landing on the tick itself suppresses that tick's gravity step
         bus.bird_down <= tick && !flap_seen && !bus.flap;
         bus.score_clr <= state == CLEAR;
         bus.game_over <= state_n == DEAD;
         bus.state_o   <= state_n;
      end
`ifdef GAME_SEQUENCER_SPEEDUP_EN
   localparam logic [CW:0] FLOOR = (CW+1)'(MIN_DIV + DIV_STEP);
   always_ff @(posedge clk or posedge reset)
      if (reset) cur_div <= CW'(TICK_DIV);
      else if (state == CLEAR) cur_div <= CW'(TICK_DIV);
      else if (play && bus.score_carry)
         cur_div <= ({1'b0, cur_div} >= FLOOR) ? cur_div - CW'(DIV_STEP) : CW'(MIN_DIV);
`else
   assign cur_div = CW'(TICK_DIV);
`endif
endmodule
